// File: rtl/led_scan_driver_if.sv
// Display-side bundle for the 4-digit scan driver: digit patterns and
// update handshake in, anode/segment pins and frame pulse out.
interface led_scan_driver_if;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] in3;
    logic       update_req;
    logic       update_ack;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame_done;

    modport master (
        output in0, in1, in2, in3, update_req,
        input  update_ack, an, seg, frame_done
    );

    modport slave (
        input  in0, in1, in2, in3, update_req,
        output update_ack, an, seg, frame_done
    );
endinterface

// File: rtl/led_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan driver with per-slot blanking
// and frame-boundary shadow loading via a req/ack handshake.
module led_scan_driver #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 500
) (
    input  logic               clk,
    input  logic               rst,
    led_scan_driver_if.slave   bus
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    sh_q [4];
    logic [7:0]    sh_d [4];
    logic          pending_q, pending_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          ack_q, ack_d;
    logic          fd_q, fd_d;

    phase_e        phase;
    logic          slot_end;
    logic          boundary;
    logic          load;

    always_comb begin
        phase     = (cnt_q < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
        slot_end  = (cnt_q == CNT_LAST);
        boundary  = slot_end && (idx_q == 2'd3);
        load      = boundary && (pending_q || bus.update_req);

        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;

        an_d      = '1;
        seg_d     = '1;
        if (phase == PH_DRIVE) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = ~sh_q[idx_q];
        end

        fd_d      = boundary;
        ack_d     = load;

        sh_d[0]   = sh_q[0];
        sh_d[1]   = sh_q[1];
        sh_d[2]   = sh_q[2];
        sh_d[3]   = sh_q[3];
        if (load) begin
            sh_d[0] = bus.in0;
            sh_d[1] = bus.in1;
            sh_d[2] = bus.in2;
            sh_d[3] = bus.in3;
        end

        // A boundary either loads (consuming the request) or had nothing pending.
        pending_d = boundary ? 1'b0 : (pending_q || bus.update_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            for (int unsigned i = 0; i < 4; i++) sh_q[i] <= '0;
            pending_q <= 1'b0;
            an_q      <= '1;
            seg_q     <= '1;
            ack_q     <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            for (int unsigned i = 0; i < 4; i++) sh_q[i] <= sh_d[i];
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            ack_q     <= ack_d;
            fd_q      <= fd_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.update_ack = ack_q;
    assign bus.frame_done = fd_q;

endmodule
